// File: rtl/result_streamer_if.sv
// ============================================================================
// result_streamer_if
// Control, RAM read port and byte-stream signals of the result streamer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface result_streamer_if;
  logic        start;
  logic [15:0] cfg_out_w;
  logic [15:0] cfg_out_h;
  logic [15:0] cfg_stride;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_data_in;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;

  modport master (
    input  start, cfg_out_w, cfg_out_h, cfg_stride, mem_data_in, tx_ready,
    output busy, done, mem_addr, mem_rd_en, tx_data, tx_valid, tx_last
  );

  modport slave (
    output start, cfg_out_w, cfg_out_h, cfg_stride, mem_data_in, tx_ready,
    input  busy, done, mem_addr, mem_rd_en, tx_data, tx_valid, tx_last
  );
endinterface

`default_nettype wire

// File: rtl/result_streamer.sv
// ============================================================================
// result_streamer
// Reads the output image from byte RAM and streams it out with valid/ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_streamer #(
  parameter logic [15:0] BASE_ADDR  = 16'h4000,
  parameter int          RD_LATENCY = 2,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              aclr_n,
  result_streamer_if.master strm_io
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] w_q, w_d, h_q, h_d, stride_q, stride_d;
  logic [15:0] x_q, x_d, y_q, y_d, row_base_q, row_base_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_en_q, mem_rd_en_d;

  logic [RD_LATENCY-1:0] tag_v_q, tag_last_q;

  logic [7:0]       data_q [FIFO_DEPTH];
  logic             last_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             w_issue, w_last_px, w_credit_ok;
  logic             w_push, w_pop, w_valid, w_head_last;
  logic [CNT_W-1:0] w_outstanding;

  always_comb begin
    w_outstanding = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_outstanding = w_outstanding + CNT_W'(tag_v_q[i]);
    end
  end

  // Reserving a FIFO slot for every read in flight keeps the FIFO from
  // overflowing however long the sink stalls.
  assign w_credit_ok = (w_outstanding + count_q) < CNT_W'(FIFO_DEPTH);
  assign w_last_px   = (x_q == w_q - 16'd1) && (y_q == h_q - 16'd1);
  assign w_valid     = (count_q != '0);
  assign w_head_last = last_q[rd_ptr_q];
  assign w_pop       = w_valid && strm_io.tx_ready;
  assign w_push      = tag_v_q[RD_LATENCY-1];

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    stride_d    = stride_q;
    x_d         = x_q;
    y_d         = y_q;
    row_base_d  = row_base_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_en_d = 1'b0;
    w_issue     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (strm_io.start) begin
          w_d      = strm_io.cfg_out_w;
          h_d      = strm_io.cfg_out_h;
          stride_d = strm_io.cfg_stride;
          if ((strm_io.cfg_out_w == 16'd0) || (strm_io.cfg_out_h == 16'd0)) begin
            state_d = S_DONE;
          end else begin
            x_d        = 16'd0;
            y_d        = 16'd0;
            row_base_d = BASE_ADDR;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (w_credit_ok) begin
          w_issue     = 1'b1;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = row_base_q + x_q;
          if (x_q == w_q - 16'd1) begin
            x_d        = 16'd0;
            y_d        = y_q + 16'd1;
            row_base_d = row_base_q + stride_q;
            if (w_last_px) state_d = S_DRAIN;
          end else begin
            x_d = x_q + 16'd1;
          end
        end
      end
      S_DRAIN: begin
        if (w_pop && w_head_last && (w_outstanding == '0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      stride_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      row_base_q  <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      stride_q    <= stride_d;
      x_q         <= x_d;
      y_q         <= y_d;
      row_base_q  <= row_base_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
    end
  end

  // Read tags travel alongside the RAM pipeline and mark when data returns.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      tag_v_q    <= '0;
      tag_last_q <= '0;
    end else begin
      tag_v_q[0]    <= w_issue;
      tag_last_q[0] <= w_issue && w_last_px;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_v_q[i]    <= tag_v_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        data_q[wr_ptr_q] <= strm_io.mem_data_in;
        last_q[wr_ptr_q] <= tag_last_q[RD_LATENCY-1];
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign strm_io.busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign strm_io.done      = (state_q == S_DONE);
  assign strm_io.mem_addr  = mem_addr_q;
  assign strm_io.mem_rd_en = mem_rd_en_q;
  assign strm_io.tx_data   = data_q[rd_ptr_q];
  assign strm_io.tx_valid  = w_valid;
  assign strm_io.tx_last   = w_valid && w_head_last;

endmodule

`default_nettype wire

// File: tb/tb_result_streamer.sv
// ============================================================================
// tb_result_streamer
// Scoreboard bench: a frame-level model predicts reads and stream bytes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_result_streamer;
  logic clk = 1'b0;
  logic aclr_n;
  always #5 clk = ~clk;

  result_streamer_if if0();
  result_streamer_if if1();

  result_streamer u_dut (
    .clk     (clk),
    .aclr_n  (aclr_n),
    .strm_io (if0)
  );

  result_streamer #(.BASE_ADDR(16'hFFFE)) u_wrap (
    .clk     (clk),
    .aclr_n  (aclr_n),
    .strm_io (if1)
  );

  // RAM model: data for an address registered at edge k is valid after edge k+1.
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if0.mem_data_in <= ram[if0.mem_addr];
    if1.mem_data_in <= ram[if1.mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [7:0] data; logic last; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] addr_q[$];

  // Reference: the frame is the row-major walk of w x h bytes at base+y*stride+x.
  task automatic model_frame(input int w, input int h, input int stride, input logic [15:0] base);
    logic [15:0] a;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        a = 16'(int'(base) + y * stride + x);
        addr_q.push_back(a);
        exp_q.push_back('{ram[a], (x == w - 1) && (y == h - 1)});
      end
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_done = 0, n_acc = 0, n_rd = 0, n_vcyc = 0;
  int   t_done = -1, t_first_valid = -1, t_first_rd = -1;
  logic prev_stall = 1'b0, prev_done = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] a;
    if (!aclr_n) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(if0.tx_valid), 32'd1);
        check("hold_data", 32'(if0.tx_data), 32'(prev_data));
        check("hold_last", 32'(if0.tx_last), 32'(prev_last));
      end
      if (if0.mem_rd_en) begin
        n_rd++;
        if (t_first_rd < 0) t_first_rd = cyc;
        check("rd_expected", 32'(addr_q.size() != 0), 32'd1);
        if (addr_q.size() != 0) begin
          a = addr_q.pop_front();
          check("rd_addr", 32'(if0.mem_addr), 32'(a));
        end
      end
      if (if0.tx_valid) begin
        n_vcyc++;
        if (t_first_valid < 0) t_first_valid = cyc;
      end
      if (if0.tx_valid && if0.tx_ready) begin
        n_acc++;
        check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tx_data", 32'(if0.tx_data), 32'(e.data));
          check("tx_last", 32'(if0.tx_last), 32'(e.last));
        end
      end
      if (if0.done) begin
        check("done_width", 32'(prev_done), 32'd0);
        check("busy_in_done", 32'(if0.busy), 32'd0);
        n_done++;
        t_done = cyc;
      end
      prev_done  = if0.done;
      prev_stall = if0.tx_valid && !if0.tx_ready;
      prev_data  = if0.tx_data;
      prev_last  = if0.tx_last;
    end
  end

  logic [15:0] addr1_q[$];
  logic [8:0]  byte1_q[$];
  int          n_done1 = 0;
  always @(negedge clk) begin
    if (aclr_n) begin
      if (if1.mem_rd_en) addr1_q.push_back(if1.mem_addr);
      if (if1.tx_valid && if1.tx_ready) byte1_q.push_back({if1.tx_last, if1.tx_data});
      if (if1.done) n_done1++;
    end
  end

  // Ready driver: 0 = fixed level, 1 = random, 2 = toggling.
  int   rdy_mode  = 0;
  logic rdy_fixed = 1'b1;
  initial begin
    if0.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1)      if0.tx_ready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 2) if0.tx_ready = ~if0.tx_ready;
      else                    if0.tx_ready = rdy_fixed;
    end
  end

  int t_start = 0;

  task automatic start_frame(input int w, input int h, input int stride);
    @(posedge clk);
    #1;
    t_done = -1; t_first_valid = -1; t_first_rd = -1;
    if0.cfg_out_w  = 16'(w);
    if0.cfg_out_h  = 16'(h);
    if0.cfg_stride = 16'(stride);
    if0.start      = 1'b1;
    if (w != 0 && h != 0) model_frame(w, h, stride, 16'h4000);
    @(posedge clk);
    #1;
    if0.start      = 1'b0;
    t_start        = cyc;
    if0.cfg_out_w  = 16'($urandom);
    if0.cfg_out_h  = 16'($urandom);
    if0.cfg_stride = 16'($urandom);
  endtask

  task automatic wait_done(input int budget, input int done_before);
    int k;
    k = 0;
    while (n_done == done_before && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(n_done != done_before), 32'd1);
    repeat (4) @(negedge clk);
    check("done_count", 32'(n_done - done_before), 32'd1);
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    check("addr_drained", 32'(addr_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(if0.busy), 32'd0);
    check({tag, "_done"},  32'(if0.done), 32'd0);
    check({tag, "_addr"},  32'(if0.mem_addr), 32'd0);
    check({tag, "_rden"},  32'(if0.mem_rd_en), 32'd0);
    check({tag, "_valid"}, 32'(if0.tx_valid), 32'd0);
    check({tag, "_last"},  32'(if0.tx_last), 32'd0);
    check({tag, "_data"},  32'(if0.tx_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, v0, a0, k, w, h;
    logic [15:0] wa;

    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    aclr_n = 1'b0;
    if0.start = 1'b0; if0.cfg_out_w = '0; if0.cfg_out_h = '0; if0.cfg_stride = '0;
    if1.start = 1'b0; if1.cfg_out_w = '0; if1.cfg_out_h = '0; if1.cfg_stride = '0;
    if1.tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    aclr_n = 1'b1;

    // Basic 2x2 frame with known bytes and exact latencies.
    ram[16'h4000] = 8'h10; ram[16'h4001] = 8'h11;
    ram[16'h4004] = 8'h14; ram[16'h4005] = 8'h15;
    d0 = n_done;
    start_frame(2, 2, 4);
    wait_done(40, d0);
    check("basic_first_rd", 32'(t_first_rd - t_start), 32'd1);
    check("basic_first_valid", 32'(t_first_valid - t_start), 32'd3);
    check("basic_done_lat", 32'(t_done - t_start), 32'd7);

    // Back-pressure: sink stalled from the start, then toggling / held low.
    rdy_fixed = 1'b0; rdy_mode = 0;
    d0 = n_done; r0 = n_rd;
    start_frame(4, 2, 6);
    repeat (10) @(negedge clk);
    check("credit_stall_reads", 32'(n_rd - r0), 32'd4);
    rdy_mode = 2;
    repeat (4) @(posedge clk);
    rdy_mode = 0; rdy_fixed = 1'b0;
    repeat (6) @(posedge clk);
    rdy_mode = 2;
    wait_done(80, d0);
    rdy_mode = 0; rdy_fixed = 1'b1;

    // Zero-size frame, then the smallest real frame.
    d0 = n_done; r0 = n_rd; v0 = n_vcyc;
    start_frame(0, 5, 4);
    wait_done(10, d0);
    check("zero_done_lat", 32'((t_done - t_start) <= 1), 32'd1);
    check("zero_no_reads", 32'(n_rd - r0), 32'd0);
    check("zero_no_valid", 32'(n_vcyc - v0), 32'd0);
    d0 = n_done; a0 = n_acc;
    start_frame(1, 1, 1);
    wait_done(20, d0);
    check("single_byte", 32'(n_acc - a0), 32'd1);

    // Second start during ISSUE must be ignored.
    d0 = n_done;
    start_frame(3, 3, 5);
    @(posedge clk); #1;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    wait_done(60, d0);
    repeat (10) @(negedge clk);
    check("busy_start_one_done", 32'(n_done - d0), 32'd1);

    // Randomized frames with random sink behaviour.
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      w = int'($urandom_range(1, 5));
      h = int'($urandom_range(1, 4));
      d0 = n_done;
      start_frame(w, h, w + int'($urandom_range(0, 5)));
      wait_done(w * h * 8 + 40, d0);
    end
    rdy_mode = 0; rdy_fixed = 1'b1;

    // Reset in the middle of a 16-byte frame, then a clean rerun.
    d0 = n_done; a0 = n_acc;
    start_frame(4, 4, 4);
    k = 0;
    while ((n_acc - a0) < 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("reset_reached_3_bytes", 32'((n_acc - a0) >= 3), 32'd1);
    #2;
    aclr_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    @(negedge clk);
    #2;
    aclr_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_no_done", 32'(n_done - d0), 32'd0);
    d0 = n_done; a0 = n_acc;
    start_frame(4, 4, 4);
    wait_done(60, d0);
    check("rerun_bytes", 32'(n_acc - a0), 32'd16);

    // Address wrap on the instance based at 16'hFFFE.
    @(posedge clk); #1;
    if1.cfg_out_w = 16'd4; if1.cfg_out_h = 16'd1; if1.cfg_stride = 16'd4;
    if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    k = 0;
    while (n_done1 == 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("wrap_done", 32'(n_done1), 32'd1);
    check("wrap_reads", 32'(addr1_q.size()), 32'd4);
    check("wrap_bytes", 32'(byte1_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      wa = 16'hFFFE + 16'(i);
      if (i < addr1_q.size()) check("wrap_addr", 32'(addr1_q[i]), 32'(wa));
      if (i < byte1_q.size()) check("wrap_byte", 32'(byte1_q[i]), 32'({(i == 3), ram[wa]}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/result_streamer.md
# result_streamer

Downstream readout stage of the downscaler. After the interpolation control unit finishes writing the output image into the shared 64 KiB byte RAM, this block reads that region pixel by pixel and emits it as a byte stream with a valid/ready handshake, for transfer to the host link. It absorbs the RAM's fixed read latency with a small credit-controlled FIFO so that back-pressure never loses data.

## Interface
- BASE_ADDR, 16'h4000, byte address of output pixel (0,0).
- RD_LATENCY, 2, clock edges from `mem_addr` registered to `mem_data_in` valid (1..4).
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥ RD_LATENCY+1).

Ports:
- clk  in  1  clock, rising edge.
- aclr_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle start request; honoured only in IDLE.
- cfg_out_w  in  16  output image width in pixels.
- cfg_out_h  in  16  output image height in pixels.
- cfg_stride  in  16  row pitch in RAM (bytes); equals the source width used by the writer.
- busy  out  1  high from the cycle after accepted start until DONE.
- done  out  1  one-cycle pulse after the last byte is accepted.
- mem_addr  out  16  registered RAM read address.
- mem_rd_en  out  1  high in cycles where `mem_addr` carries a new read request.
- mem_data_in  in  8  RAM read data.
- tx_data  out  8  stream byte (FIFO head).
- tx_valid  out  1  FIFO not empty.
- tx_last  out  1  qualifies the final pixel of the frame.
- tx_ready  in  1  sink accepts when `tx_valid && tx_ready`.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on `start`, latch `cfg_*`; if width or height is 0 → DONE; else clear x=y=0, row_base=BASE_ADDR → ISSUE.
- ISSUE: each cycle with `outstanding + fifo_count < FIFO_DEPTH`: drive `mem_addr = row_base + x` (16-bit wrap), `mem_rd_en=1`, advance x; at x = w−1, x←0, y++, row_base += stride. After the read for (w−1,h−1) is issued → DRAIN.
- Return path: RD_LATENCY-deep shift register of read tags (valid, last); when a tag exits, `mem_data_in` and `last` are pushed into the FIFO.
- `outstanding` = tags in flight (0..RD_LATENCY). The credit check guarantees the FIFO never overflows, regardless of `tx_ready`.
- FIFO: simultaneous push and pop are allowed, including when full or when count=1.
- DRAIN: wait for outstanding=0 and a pop of the entry with last=1 → DONE.
- DONE: `done=1`, `busy=0` for one cycle → IDLE.
- `start` in any state other than IDLE is ignored. `cfg_*` changes after acceptance have no effect.
- Pixel counters are 16-bit. The frame size w·h is not otherwise limited; addresses wrap modulo 2^16.

## Timing
- Reset values: `busy=0`, `done=0`, `mem_addr=0`, `mem_rd_en=0`, `tx_valid=0`, `tx_last=0`, `tx_data=0`, FIFO empty, state IDLE.
- The start edge is E0. At E0+1, `mem_addr=BASE_ADDR` and `mem_rd_en=1`. The first byte is pushed at E0+1+RD_LATENCY and `tx_valid` is high after that edge.
- Default parameters: start at E0 → `tx_valid` after E3.
- With `tx_ready` held high: 1 byte/cycle sustained. A frame of N pixels ends with `done` high N+RD_LATENCY+1 cycles after E0.
- `tx_data`, `tx_last` must hold stable while `tx_valid && !tx_ready`.
- Zero-size frame: `done` pulse in the cycle after E0+1 (IDLE→DONE→IDLE). No `mem_rd_en` and no `tx_valid`.
- `aclr_n` low mid-frame: all outputs return to reset values immediately. In-flight data and FIFO contents are discarded, and no `done` is produced.

## Test plan
- Basic: RAM[0x4000..]=row-major, w=h=2, stride=4, bytes {0x10,0x11,0x14,0x15} at 0x4000,0x4001,0x4004,0x4005, `tx_ready`=1 → stream 10,11,14,15. `tx_last` only on 15. `done` one cycle, 7 cycles after start.
- Back-pressure: w=4,h=2, `tx_ready` toggling 1/0 and held low 6 cycles → all 8 bytes in order with no duplicates. `mem_rd_en` stalls once 4 credits are used. Data stable while stalled.
- Zero size: w=0,h=5 → `done` pulse, no reads, `tx_valid` never high. Then w=1,h=1 → a single byte with `tx_last=1`.
- Start while busy: second `start` during ISSUE → ignored, exactly one frame and one `done`.
- Reset mid-stream: `aclr_n` low after 3 bytes of a 16-byte frame → outputs at reset values. A new `start` streams a full 16-byte frame from pixel 0.
- Address wrap: BASE_ADDR=16'hFFFE, w=4,h=1 → reads at FFFE, FFFF, 0000, 0001.
